// File: rtl/host_mem_rd_burst_gen_if.sv
// host_mem_rd_burst_gen_if: command, Avalon read and return-stream signals of the read burst generator
interface host_mem_rd_burst_gen_if #(
  parameter int ADDR_W = 42,
  parameter int DATA_W = 512,
  parameter int LEN_W  = 20
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [5:0]        avm_burstcount;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, avm_waitrequest, avm_readdata, avm_readdatavalid,
    output cmd_ready, avm_address, avm_read, avm_burstcount, rd_data, rd_valid, busy, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  cmd_ready, avm_address, avm_read, avm_burstcount, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/host_mem_rd_burst_gen.sv
// host_mem_rd_burst_gen: splits (line address, length) commands into page-safe, credit-limited Avalon read bursts
module host_mem_rd_burst_gen #(
  parameter int ADDR_W          = 42,
  parameter int DATA_W          = 512,
  parameter int LEN_W           = 20,
  parameter int MAX_BURST       = 32,
  parameter int PAGE_LINES      = 64,
  parameter int MAX_OUTSTANDING = 128
) (
  input logic clk,
  input logic reset_n,
  host_mem_rd_burst_gen_if.master bus
);
  localparam int PB = $clog2(PAGE_LINES);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  if (MAX_BURST > PAGE_LINES / 2 || MAX_BURST > 63 || MAX_OUTSTANDING < MAX_BURST ||
      PAGE_LINES < 2 || (PAGE_LINES & (PAGE_LINES - 1)) != 0) begin : g_bad_params
    $fatal(1, "host_mem_rd_burst_gen: illegal parameter combination");
  end
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [LEN_W-1:0]  remaining, rem_n, to_recv;
  logic [OW-1:0]     outstanding, out_n;
  logic [DATA_W-1:0] data_q;
  logic              acc, rdv_ok, can_issue;
  logic [31:0]       to_page, lim;
  logic [5:0]        b;
  assign bus.rd_data = data_q;
  // Next burst is sized from post-acceptance state so bursts can go out back-to-back.
  always_comb begin
    acc       = bus.avm_read && !bus.avm_waitrequest;
    rdv_ok    = bus.avm_readdatavalid && to_recv != '0;
    addr_n    = acc ? addr + ADDR_W'(bus.avm_burstcount) : addr;
    rem_n     = acc ? remaining - LEN_W'(bus.avm_burstcount) : remaining;
    out_n     = OW'(32'(outstanding) + (acc ? 32'(bus.avm_burstcount) : 32'd0) - (rdv_ok ? 32'd1 : 32'd0));
    to_page   = 32'(PAGE_LINES) - 32'(addr_n[PB-1:0]);
    lim       = to_page < 32'(MAX_BURST) ? to_page : 32'(MAX_BURST);
    b         = 32'(rem_n) < lim ? 6'(rem_n) : 6'(lim);
    can_issue = state == ISSUE && rem_n != '0 && 32'(out_n) + 32'(b) <= 32'(MAX_OUTSTANDING);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      bus.cmd_ready      <= 1'b1;
      bus.avm_read       <= 1'b0;
      bus.avm_address    <= '0;
      bus.avm_burstcount <= '0;
      bus.rd_valid       <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      data_q             <= '0;
      addr               <= '0;
      remaining          <= '0;
      to_recv            <= '0;
      outstanding        <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.rd_valid <= rdv_ok;
      if (rdv_ok) begin
        data_q  <= bus.avm_readdata;
        to_recv <= to_recv - LEN_W'(1);
      end
      outstanding <= out_n;
      addr        <= addr_n;
      remaining   <= rem_n;
      // A stalled request keeps address, burstcount and read untouched.
      if (!(bus.avm_read && bus.avm_waitrequest)) begin
        bus.avm_read <= can_issue;
        if (can_issue) begin
          bus.avm_address    <= addr_n;
          bus.avm_burstcount <= b;
        end
      end
      case (state)
        IDLE: if (bus.cmd_valid) begin
          bus.cmd_ready <= 1'b0;
          bus.busy      <= 1'b1;
          addr          <= bus.cmd_addr;
          remaining     <= bus.cmd_len;
          to_recv       <= bus.cmd_len;
          state         <= bus.cmd_len == '0 ? DONE : ISSUE;
        end
        ISSUE: state <= rem_n == '0 ? DRAIN : ISSUE;
        DRAIN: state <= to_recv == '0 ? DONE : DRAIN;
        DONE: begin
          state         <= IDLE;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end
`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!reset_n) !(bus.avm_readdatavalid && to_recv == '0))
    else $error("readdatavalid with no lines outstanding");
`endif
endmodule
